// File: rtl/uart_pkg.sv
// Framing constants and frame FSM states shared by the multi-byte UART
// transmitter and receiver so both ends agree on the packet layout.
package uart_pkg;

  localparam int          DEF_CLK_FREQ = 50_000_000;
  localparam int          DEF_UART_BPS = 115200;
  localparam logic [7:0]  DEF_HEAD0    = 8'h55;
  localparam logic [7:0]  DEF_HEAD1    = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H0,
    S_H1,
    S_LEN,
    S_DATA,
    S_CSUM
  } frame_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// Bit-level 8N1 serializer. tx_done is high during the last clock of the stop
// bit so the caller can chain the next byte with no idle gap between bytes.
module uart_byte_tx #(
  parameter int BPS_CNT = 434
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  localparam int            CW        = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BPS_CNT - 1);

  logic          busy_q, busy_d;
  logic          txd_q, txd_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          byte_end;

  // Bit 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit.
  assign byte_end = busy_q && (baud_cnt_q == BAUD_LAST) && (bit_cnt_q == 4'd9);

  always_comb begin
    busy_d     = busy_q;
    txd_d      = txd_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    if (busy_q) begin
      if (baud_cnt_q == BAUD_LAST) begin
        baud_cnt_d = '0;
        if (bit_cnt_q == 4'd9) begin
          busy_d = 1'b0;
          txd_d  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          txd_d     = (bit_cnt_q < 4'd8) ? data_q[bit_cnt_q[2:0]] : 1'b1;
        end
      end else begin
        baud_cnt_d = baud_cnt_q + 1'b1;
      end
    end
    if (tx_start && (!busy_q || byte_end)) begin
      busy_d     = 1'b1;
      txd_d      = 1'b0;
      baud_cnt_d = '0;
      bit_cnt_d  = 4'd0;
      data_d     = tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_q     <= 1'b0;
      txd_q      <= 1'b1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      data_q     <= 8'd0;
    end else begin
      busy_q     <= busy_d;
      txd_q      <= txd_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
    end
  end

  assign tx_busy = busy_q;
  assign tx_done = byte_end;
  assign txd     = txd_q;

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Packet UART transmitter: buffers payload bytes, then on send emits
// HEAD0 HEAD1 LEN payload CSUM as one continuous 8N1 stream.
module uart_mult_byte_tx
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ = DEF_CLK_FREQ,
  parameter int         UART_BPS = DEF_UART_BPS,
  parameter int         MAX_LEN  = 16,
  parameter logic [7:0] HEAD0    = DEF_HEAD0,
  parameter logic [7:0] HEAD1    = DEF_HEAD1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       send,
  output logic [7:0] buf_cnt,
  output logic       busy,
  output logic       done,
  output logic       wr_err,
  output logic       uart_txd
);

  localparam int         BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int         AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] FULL    = 8'(MAX_LEN);

  frame_state_e state_q, state_d;
  logic [7:0]   buf_cnt_q, buf_cnt_d;
  logic [7:0]   sum_q, sum_d;
  logic [7:0]   len_q, len_d;
  logic [7:0]   csum_q, csum_d;
  logic [7:0]   idx_q, idx_d;
  logic [7:0]   rd_data_q;
  logic         done_q, done_d;
  logic         wr_err_q, wr_err_d;
  logic [7:0]   mem [MAX_LEN];

  logic         wr_ok;
  logic [7:0]   cnt_after, sum_after;
  logic         tx_start, tx_done, tx_busy;
  logic [7:0]   tx_data;

  // A write in the same cycle as send is folded into LEN and the checksum.
  assign wr_ok     = wr_en && (state_q == S_IDLE) && (buf_cnt_q != FULL);
  assign cnt_after = buf_cnt_q + {7'd0, wr_ok};
  assign sum_after = sum_q + (wr_ok ? wr_data : 8'd0);

  always_comb begin
    state_d   = state_q;
    buf_cnt_d = cnt_after;
    sum_d     = sum_after;
    len_d     = len_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    wr_err_d  = wr_en && !wr_ok;
    tx_start  = 1'b0;
    tx_data   = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (send) begin
          state_d  = S_H0;
          tx_start = 1'b1;
          tx_data  = HEAD0;
          len_d    = cnt_after;
          csum_d   = cnt_after + sum_after;
          idx_d    = 8'd0;
        end
      end
      S_H0: begin
        if (tx_done) begin
          state_d  = S_H1;
          tx_start = 1'b1;
          tx_data  = HEAD1;
        end
      end
      S_H1: begin
        if (tx_done) begin
          state_d  = S_LEN;
          tx_start = 1'b1;
          tx_data  = len_q;
        end
      end
      S_LEN, S_DATA: begin
        // rd_data_q already holds mem[idx_q]; the address settled long before.
        if (tx_done) begin
          tx_start = 1'b1;
          if (idx_q == len_q) begin
            state_d = S_CSUM;
            tx_data = csum_q;
          end else begin
            state_d = S_DATA;
            tx_data = rd_data_q;
            idx_d   = idx_q + 8'd1;
          end
        end
      end
      S_CSUM: begin
        if (tx_done) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          buf_cnt_d = 8'd0;
          sum_d     = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      buf_cnt_q <= 8'd0;
      sum_q     <= 8'd0;
      len_q     <= 8'd0;
      csum_q    <= 8'd0;
      idx_q     <= 8'd0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_cnt_q <= buf_cnt_d;
      sum_q     <= sum_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      wr_err_q  <= wr_err_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_ok) begin
      mem[buf_cnt_q[AW-1:0]] <= wr_data;
    end
    rd_data_q <= mem[idx_q[AW-1:0]];
  end

  uart_byte_tx #(
    .BPS_CNT(BPS_CNT)
  ) u_byte_tx (
    .clk     (sys_clk),
    .srst    (sys_rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .txd     (uart_txd)
  );

  assign buf_cnt = buf_cnt_q;
  assign busy    = tx_busy;
  assign done    = done_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Directed bench for uart_mult_byte_tx with a short bit period; a negedge
// monitor decodes uart_txd into {stop, byte} entries.
module tb_uart_mult_byte_tx;

  localparam int BPS  = 8;
  localparam int BYTE = 10 * BPS;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       send = 1'b0;
  logic [7:0] buf_cnt;
  logic       busy, done, wr_err, uart_txd;

  int errors = 0;
  int checks = 0;

  uart_mult_byte_tx #(
    .CLK_FREQ(800), .UART_BPS(100), .MAX_LEN(16), .HEAD0(8'h55), .HEAD1(8'hAA)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_data(wr_data),
    .send(send), .buf_cnt(buf_cnt), .busy(busy), .done(done),
    .wr_err(wr_err), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  logic [8:0] rx_q[$];
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_sh = 8'd0;

  always @(negedge clk) begin
    if (sys_rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_txd === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % BPS == BPS / 2) begin
        if (mon_cnt / BPS <= 8) begin
          mon_sh[mon_cnt / BPS - 1] = uart_txd;
        end else begin
          rx_q.push_back({uart_txd, mon_sh});
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] b, output logic err);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_data = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
    err = wr_err;
  endtask

  // Pulses send (optionally with a write) and follows the frame to its end.
  task automatic send_and_collect(input bit with_wr, input logic [7:0] wb, input bit poke,
                                  output logic lat_busy, output logic lat_txd,
                                  output int busy_cycles, output logic done_end,
                                  output logic done_next, output logic busy_next,
                                  output logic [7:0] cnt_end, output logic poke_err);
    rx_q.delete();
    poke_err = 1'b0;
    @(posedge clk); #1;
    send = 1'b1;
    if (with_wr) begin wr_en = 1'b1; wr_data = wb; end
    @(posedge clk); #1;
    send = 1'b0; wr_en = 1'b0;
    lat_busy = busy; lat_txd = uart_txd;
    busy_cycles = 1;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (poke && busy_cycles == 40) begin
        wr_en = 1'b1; wr_data = 8'hEE; send = 1'b1;
      end else if (poke && busy_cycles == 41) begin
        poke_err = wr_err; wr_en = 1'b0; send = 1'b0;
      end
      if (!busy) break;
      busy_cycles++;
    end
    done_end = done; cnt_end = buf_cnt;
    @(posedge clk); #1;
    done_next = done; busy_next = busy;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", uart_txd); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
    if (buf_cnt !== 8'd0) begin errors++; $display("FAIL reset_buf_cnt: got %0d expected 0", buf_cnt); end
    sys_rst = 1'b0;
    $display("reset: txd=%b busy=%b buf_cnt=%0d", uart_txd, busy, buf_cnt);
  endtask

  task automatic test_frame(input string name, input logic [7:0] payload[$], input bit with_wr,
                            input logic [7:0] wb, input bit poke, input logic [7:0] exp[$]);
    logic e, lb, lt, de, dn, bn, pe;
    logic [7:0] ce;
    int bc;
    logic [7:0] exp_cnt;
    foreach (payload[i]) write_byte(payload[i], e);
    exp_cnt = 8'(payload.size() > 16 ? 16 : payload.size());
    checks++;
    if (buf_cnt !== exp_cnt) begin errors++; $display("FAIL %s_buf_cnt: got %0d expected %0d", name, buf_cnt, exp_cnt); end
    if (payload.size() > 16) begin
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL %s_overflow_wr_err: got %b expected 1", name, e); end
    end
    send_and_collect(with_wr, wb, poke, lb, lt, bc, de, dn, bn, ce, pe);
    checks += 7;
    if (lb !== 1'b1 || lt !== 1'b0) begin errors++; $display("FAIL %s_latency: got busy=%b txd=%b expected busy=1 txd=0", name, lb, lt); end
    if (bc != exp.size() * BYTE) begin errors++; $display("FAIL %s_busy_len: got %0d expected %0d", name, bc, exp.size() * BYTE); end
    if (de !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1", name, de); end
    if (dn !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b expected 0", name, dn); end
    if (bn !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b expected 0", name, bn); end
    if (ce !== 8'd0) begin errors++; $display("FAIL %s_buf_cnt_end: got %0d expected 0", name, ce); end
    if (rx_q.size() != exp.size()) begin errors++; $display("FAIL %s_nbytes: got %0d expected %0d", name, rx_q.size(), exp.size()); end
    else begin
      foreach (exp[i]) begin
        checks++;
        if (rx_q[i] !== {1'b1, exp[i]}) begin errors++; $display("FAIL %s_byte%0d: got %h expected %h", name, i, rx_q[i], {1'b1, exp[i]}); end
      end
    end
    if (poke) begin
      checks++;
      if (pe !== 1'b1) begin errors++; $display("FAIL %s_busy_wr_err: got %b expected 1", name, pe); end
    end
    $display("%s: bytes=%0d busy_cycles=%0d done=%b", name, rx_q.size(), bc, de);
  endtask

  task automatic test_basic();
    test_frame("basic", '{8'h01, 8'h02, 8'h03}, 1'b0, 8'h00, 1'b0,
               '{8'h55, 8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09});
  endtask

  task automatic test_empty();
    logic [7:0] none[$];
    test_frame("empty", none, 1'b0, 8'h00, 1'b0, '{8'h55, 8'hAA, 8'h00, 8'h00});
  endtask

  task automatic test_csum_wrap();
    test_frame("csum_wrap", '{8'hFF, 8'hFF}, 1'b0, 8'h00, 1'b0,
               '{8'h55, 8'hAA, 8'h02, 8'hFF, 8'hFF, 8'h00});
  endtask

  task automatic test_overflow_busy();
    logic [7:0] p[$];
    logic [7:0] x[$];
    for (int i = 1; i <= 16; i++) p.push_back(8'(i));
    p.push_back(8'h77);
    x = '{8'h55, 8'hAA, 8'h10};
    for (int i = 1; i <= 16; i++) x.push_back(8'(i));
    x.push_back(8'h98);
    test_frame("overflow", p, 1'b0, 8'h00, 1'b1, x);
  endtask

  task automatic test_same_cycle();
    test_frame("same_cycle", '{8'h10}, 1'b1, 8'h20, 1'b0,
               '{8'h55, 8'hAA, 8'h02, 8'h10, 8'h20, 8'h32});
  endtask

  task automatic test_mid_reset();
    logic e;
    int seen_done = 0;
    write_byte(8'h11, e);
    write_byte(8'h22, e);
    @(posedge clk); #1;
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    repeat (2 * BYTE + 20) @(posedge clk);
    #1;
    sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    checks += 3;
    if (uart_txd !== 1'b1) begin errors++; $display("FAIL midrst_txd: got %b expected 1", uart_txd); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (buf_cnt !== 8'd0) begin errors++; $display("FAIL midrst_buf_cnt: got %0d expected 0", buf_cnt); end
    for (int i = 0; i < 3 * BYTE; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen_done != 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen_done); end
    $display("mid_reset: txd=%b busy=%b buf_cnt=%0d", uart_txd, busy, buf_cnt);
    test_frame("after_reset", '{8'hA5}, 1'b0, 8'h00, 1'b0, '{8'h55, 8'hAA, 8'h01, 8'hA5, 8'hA6});
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_csum_wrap();
    test_overflow_busy();
    test_same_cycle();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
